// File: rtl/icache_pkg.sv
// icache_pkg: shared sizes, status-byte bit positions and refill FSM states.
// Status byte layout: way w owns bit 2w (valid) and bit 2w+1 (use).
package icache_pkg;
  localparam int TAG_BITS        = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_DATA_WIDTH = 20;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int NUM_WAYS        = 4;
  localparam int WAY_BITS        = 2;
  localparam int STATUS_BITS     = 2 * NUM_WAYS;
  localparam int BLOCK_BITS      = WORD_DATA_WIDTH * WORDS_PER_BLOCK;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_WRITE, S_RESP} state_e;

  function automatic int valid_bit(input int w);
    return 2 * w;
  endfunction

  function automatic int use_bit(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: picks the refill victim way and the status byte written back with it.
// Ports: status_i (current set status) -> way_o (victim), status_o (status after fill).
// Victim is the lowest invalid way, else the lowest way with use=0, else way 0.
module icache_victim_sel
  import icache_pkg::*;
(
  input  logic [STATUS_BITS-1:0] status_i,
  output logic [WAY_BITS-1:0]    way_o,
  output logic [STATUS_BITS-1:0] status_o
);
  logic found;
  logic all_use;
  always_comb begin
    way_o = '0;
    found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!found && !status_i[valid_bit(w)]) begin
        way_o = WAY_BITS'(w);
        found = 1'b1;
      end
    for (int w = 0; w < NUM_WAYS; w++)
      if (!found && !status_i[use_bit(w)]) begin
        way_o = WAY_BITS'(w);
        found = 1'b1;
      end
    status_o = status_i;
    for (int w = 0; w < NUM_WAYS; w++)
      if (way_o == WAY_BITS'(w)) begin
        status_o[valid_bit(w)] = 1'b1;
        status_o[use_bit(w)]   = 1'b1;
      end
    all_use = 1'b1;
    for (int w = 0; w < NUM_WAYS; w++) all_use = all_use & status_o[use_bit(w)];
    // Once every way is marked used, only the freshly filled way keeps its use bit.
    for (int w = 0; w < NUM_WAYS; w++)
      if (all_use && way_o != WAY_BITS'(w)) status_o[use_bit(w)] = 1'b0;
  end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: registers cache hits to the decoder and runs the block refill on a miss.
// Ports: lookup result (i_valid/i_cache_hit/i_word_data/i_addr/i_status_data), decoder
// handshake (o_word_valid/o_word_data/i_ready), pipeline stall o_halt, memory request
// (o_mem_req_*/i_mem_req_ready), response beats (i_mem_rsp_*), array write port (o_fill_*).
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_WIDTH = TAG_BITS + INDEX_BITS + OFFSET_BITS
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       i_valid,
  input  logic                       i_cache_hit,
  input  logic [WORD_DATA_WIDTH-1:0] i_word_data,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic [STATUS_BITS-1:0]     i_status_data,
  input  logic                       i_ready,
  output logic                       o_halt,
  output logic                       o_word_valid,
  output logic [WORD_DATA_WIDTH-1:0] o_word_data,
  output logic                       o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]      o_mem_req_addr,
  input  logic                       i_mem_req_ready,
  input  logic                       i_mem_rsp_valid,
  input  logic [WORD_DATA_WIDTH-1:0] i_mem_rsp_data,
  output logic                       o_fill_we,
  output logic [INDEX_BITS-1:0]      o_fill_index,
  output logic [WAY_BITS-1:0]        o_fill_way,
  output logic [TAG_BITS-1:0]        o_fill_tag,
  output logic [BLOCK_BITS-1:0]      o_fill_data,
  output logic [STATUS_BITS-1:0]     o_fill_status
);
  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [WAY_BITS-1:0]        way_q, way_d;
  logic [STATUS_BITS-1:0]     nstat_q, nstat_d;
  logic [OFFSET_BITS-1:0]     cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0]      blk_q, blk_d;
  logic                       wv_q, wv_d;
  logic [WORD_DATA_WIDTH-1:0] wd_q, wd_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic [WAY_BITS-1:0]        vic_way;
  logic [STATUS_BITS-1:0]     vic_status;
  logic                       can_take;

  icache_victim_sel u_victim (
    .status_i (i_status_data),
    .way_o    (vic_way),
    .status_o (vic_status)
  );

  // A new lookup (hit or miss) is only taken once the output register is free this cycle,
  // so a pending hit word is never overwritten by a later refill response.
  assign can_take = ~wv_q | i_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    way_d   = way_q;
    nstat_d = nstat_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    wv_d    = wv_q & ~i_ready;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE:
        if (i_valid && can_take) begin
          if (i_cache_hit) begin
            wv_d = 1'b1;
            wd_d = i_word_data;
          end else begin
            state_d = S_REQ;
            addr_d  = i_addr;
            way_d   = vic_way;
            nstat_d = vic_status;
          end
        end
      S_REQ:
        if (i_mem_req_ready) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      S_FILL:
        if (i_mem_rsp_valid) begin
          blk_d[WORD_DATA_WIDTH*int'(cnt_q) +: WORD_DATA_WIDTH] = i_mem_rsp_data;
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == OFFSET_BITS'(WORDS_PER_BLOCK - 1)) ? S_WRITE : S_FILL;
        end
      S_WRITE: begin
        state_d = S_RESP;
        wv_d    = 1'b1;
        wd_d    = blk_q[WORD_DATA_WIDTH*int'(addr_q[OFFSET_BITS-1:0]) +: WORD_DATA_WIDTH];
      end
      S_RESP:
        state_d = i_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_d = (state_d == S_REQ);
  assign we_d  = (state_d == S_WRITE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      nstat_q <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      wv_q    <= 1'b0;
      wd_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      nstat_q <= nstat_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      wv_q    <= wv_d;
      wd_q    <= wd_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  // Reset masks the stall so the lookup pipeline sees no halt while the controller is held.
  assign o_halt = arst_n & (((state_q != S_IDLE) & ~((state_q == S_RESP) & i_ready)) |
                            ((state_q == S_IDLE) & i_valid & ~i_cache_hit) |
                            (wv_q & ~i_ready));

  assign o_word_valid    = wv_q;
  assign o_word_data     = wd_q;
  assign o_mem_req_valid = req_q;
  assign o_mem_req_addr  = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign o_fill_we       = we_q;
  assign o_fill_index    = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign o_fill_tag      = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign o_fill_way      = way_q;
  assign o_fill_data     = blk_q;
  assign o_fill_status   = nstat_q;
endmodule
